datapath_mc: RTL and testbench
==============================

# datapath_mc

Parametrised multicycle datapath core: instruction register with field decode, 4-entry register file, 8-function ALU with ALU result register and Z/C flags, PC and MAR. A control FSM sequences fetch/decode/execute/memory/writeback. All instruction and data traffic goes through a single req/ack memory port, and the core tolerates any number of wait states. It sits between the memory/bus model and the top level and supersedes the hand-driven datapath, whose control strobes are now generated internally.

## Interface
Parameters:
- WIDTH, 16: data/register width; must be >= 16; the instruction is IR[15:0], upper IR bits ignored.
- ADDR_W, 16: PC/MAR/mem_addr width; must be <= WIDTH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  memory request; held until ack.
- mem_we  out  1  1 = store; valid while mem_req.
- mem_addr  out  ADDR_W  PC on fetch, MAR on LD/ST.
- mem_wdata  out  WIDTH  R[rd] on ST.
- mem_rdata  in  WIDTH  sampled on the cycle mem_ack=1.
- mem_ack  in  1  completes the current request; ignored when mem_req=0.
- ir_1  out  4  opcode, IR[15:12].
- ir_2  out  2  rd, IR[11:10].
- ir_3  out  2  rs, IR[9:8].
- ir_4  out  3  IR[7:5].
- funct  out  3  IR[2:0], ALU function for opcode 0000.
- pc  out  ADDR_W  current PC.
- halted  out  1  high in HALT state.
- illegal  out  1  one-cycle pulse on undefined opcode.

## Operation
- Opcodes:
  - 0000 ALU: rd <= rd fn rs.
  - 0001 LDI: rd <= sext(IR[7:0]).
  - 0010 LD: rd <= mem[R[rs]].
  - 0011 ST: mem[R[rs]] <= R[rd].
  - 0100 BZ: if Z, PC <= PC + sext(IR[7:0]); the PC used here is already incremented.
  - 1111 HALT.
  - All others are illegal and execute as a NOP.
- ALU fn:
  - 000 add, 001 sub (rd + ~rs + 1), 010 and, 011 or, 100 xor.
  - 101 not rs.
  - 110 shl1, 111 shr1 (logical, applied to rd).
- C flag:
  - add/sub: carry-out.
  - shifts: the bit shifted out.
  - logic ops: C = 0.
- Z flag: result == 0.
- Flags are updated only in EXEC of an ALU op. LDI, LD, BZ and ST leave the flags unchanged.
- FSM states:
  - FETCH: mem_req=1, mem_we=0, addr=PC. On ack: IR <= rdata, PC <= PC+1 (mod 2^ADDR_W), go to DECODE.
  - DECODE: MAR <= R[rs][ADDR_W-1:0]. Then: ALU/BZ -> EXEC; LDI -> WB; LD/ST -> MEM; HALT -> HALT; illegal -> pulse illegal, go to FETCH.
  - EXEC: ALU op loads the ALU register and flags, then -> WB. BZ updates PC if Z, then -> FETCH.
  - MEM: mem_req=1, addr=MAR, mem_we=(ST). On ack: LD latches rdata into the ALU register and goes to WB; ST goes to FETCH.
  - WB: R[rd] <= ALU register (or sext immediate for LDI), then -> FETCH.
  - HALT: absorbing state; mem_req=0, halted=1. Only rst leaves it.
- Register writes occur only in WB. The next instruction's DECODE reads the new value, so no hazard is exposed.
- PC and branch targets wrap modulo 2^ADDR_W.

## Timing
- Reset values: state=FETCH, PC=0, IR=0, MAR=0, R0..R3=0, ALU register=0, Z=C=0, halted=0, illegal=0.
- mem_req is forced to 0 while rst=1.
- The first fetch request is issued in the first cycle after rst falls.
- mem_req and mem_we are decoded from the registered state, gated by rst.
- An ack in the same cycle as req is allowed, i.e. zero wait states.
- mem_addr, mem_we and mem_wdata remain stable from req assertion until the ack cycle.
- Latency in cycles with zero-wait ack:
  - ALU 4, LDI 3, LD 4, ST 3, BZ 3, illegal 2.
  - Each wait state adds 1 cycle per memory access.
- rst during FETCH or MEM abandons the access. A later ack from that access is ignored because mem_req=0.
- Simultaneous rst and mem_ack: reset wins, and neither IR, R nor PC updates.

## Test plan
- Reset, then program 0x1405, 0x1803, 0x0601 with zero-wait ack -> R1=0x0002, R2=0x0003, Z=0, C=1; fetch addresses 0,1,2; ALU instruction takes 4 cycles.
- 0x1CFF then 0x0D00, with R1=2 -> R3=0xFFFF then 0x0001, C=1, Z=0.
- ST then LD with 3-cycle ack delay -> mem_addr/mem_we/mem_wdata stable across the wait; PC does not advance before the fetch ack; LD result is written to rd.
- Set Z using sub of equal registers, then BZ offset 0xFE -> PC goes back 2 from the incremented PC. Same branch with Z=0 falls through. A branch at PC=0x0000 with a negative offset wraps to 0xFFFF region.
- Opcode 0x5000 -> illegal high exactly 1 cycle, registers unchanged. Then 0xF000 -> halted=1, mem_req stays 0 for 20 cycles, rst returns PC=0.
- Assert rst in a mem_req wait cycle, then deliver a stale ack -> no state change; all outputs take their reset values.

Source files
------------

// File: rtl/datapath_mc.sv
// Multicycle datapath core: IR decode, 4-entry register file, ALU with Z/C flags,
// PC/MAR, and a control FSM driving a single req/ack memory port.
module datapath_mc #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack,
    output logic [3:0]        ir_1,
    output logic [1:0]        ir_2,
    output logic [1:0]        ir_3,
    output logic [2:0]        ir_4,
    output logic [2:0]        funct,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal
);

    localparam int unsigned XW = WIDTH + 1;

    localparam logic [3:0] OP_ALU  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_BZ   = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t             state;
    logic [15:0]        ir_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  mar_q;
    logic [WIDTH-1:0]   rf [4];
    logic [WIDTH-1:0]   alu_q;
    logic               z_q;
    logic               c_q;
    logic               illegal_q;

    logic [3:0]         op;
    logic [1:0]         rd;
    logic [1:0]         rs;
    logic [WIDTH-1:0]   imm_w;
    logic [ADDR_W-1:0]  imm_a;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cy;

    assign op    = ir_q[15:12];
    assign rd    = ir_q[11:10];
    assign rs    = ir_q[9:8];
    assign imm_w = WIDTH'($signed(ir_q[7:0]));
    assign imm_a = ADDR_W'($signed(ir_q[7:0]));
    assign opa   = rf[rd];
    assign opb   = rf[rs];

    // ALU: result and carry for the function in IR[2:0]
    always_comb begin
        alu_res = '0;
        alu_cy  = 1'b0;
        case (ir_q[2:0])
            3'd0: {alu_cy, alu_res} = {1'b0, opa} + {1'b0, opb};
            3'd1: {alu_cy, alu_res} = {1'b0, opa} + {1'b0, ~opb} + XW'(1);
            3'd2: alu_res = opa & opb;
            3'd3: alu_res = opa | opb;
            3'd4: alu_res = opa ^ opb;
            3'd5: alu_res = ~opb;
            3'd6: {alu_cy, alu_res} = {opa, 1'b0};
            default: begin
                alu_res = {1'b0, opa[WIDTH-1:1]};
                alu_cy  = opa[0];
            end
        endcase
    end

    // Control FSM and all architectural state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            ir_q      <= '0;
            pc_q      <= '0;
            mar_q     <= '0;
            alu_q     <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else begin
            illegal_q <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir_q  <= mem_rdata[15:0];
                        pc_q  <= pc_q + ADDR_W'(1);
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    mar_q <= opb[ADDR_W-1:0];
                    case (op)
                        OP_ALU, OP_BZ: state <= S_EXEC;
                        OP_LDI:        state <= S_WB;
                        OP_LD, OP_ST:  state <= S_MEM;
                        OP_HALT:       state <= S_HALT;
                        default: begin
                            illegal_q <= 1'b1;
                            state     <= S_FETCH;
                        end
                    endcase
                end
                S_EXEC: begin
                    if (op == OP_ALU) begin
                        alu_q <= alu_res;
                        z_q   <= (alu_res == '0);
                        c_q   <= alu_cy;
                        state <= S_WB;
                    end else begin
                        if (z_q) pc_q <= pc_q + imm_a;
                        state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (op == OP_LD) begin
                            alu_q <= mem_rdata;
                            state <= S_WB;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    rf[rd] <= (op == OP_LDI) ? imm_w : alu_q;
                    state  <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Memory strobes come straight from the registered state so reset kills them at once
    assign mem_req   = !rst && ((state == S_FETCH) || (state == S_MEM));
    assign mem_we    = !rst && (state == S_MEM) && (op == OP_ST);
    assign mem_addr  = (state == S_MEM) ? mar_q : pc_q;
    assign mem_wdata = opa;

    assign ir_1    = ir_q[15:12];
    assign ir_2    = ir_q[11:10];
    assign ir_3    = ir_q[9:8];
    assign ir_4    = ir_q[7:5];
    assign funct   = ir_q[2:0];
    assign pc      = pc_q;
    assign halted  = (state == S_HALT);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_datapath_mc.sv
// Directed self-checking bench for datapath_mc with a wait-state memory responder.
module tb_datapath_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  ir_1;
    logic [1:0]  ir_2, ir_3;
    logic [2:0]  ir_4, funct;
    logic [15:0] pc;
    logic        halted, illegal;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [65536];
    logic        auto_ack = 1'b1;
    int          wait_n = 0;
    logic        a_ack = 1'b0, man_ack = 1'b0;
    logic [15:0] a_rdata = '0, man_rdata = '0;
    int          wcnt = 0;
    int          cyc = 0;
    logic        busy = 1'b0;
    logic [15:0] s_addr, s_wdata, s_pc;
    logic        s_we;
    int          stab_bad = 0, stab_n = 0, ill_cnt = 0;
    logic [15:0] la[$];
    int          lc[$];

    assign mem_ack   = auto_ack ? a_ack : man_ack;
    assign mem_rdata = auto_ack ? a_rdata : man_rdata;

    datapath_mc #(.WIDTH(16), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .ir_1(ir_1), .ir_2(ir_2), .ir_3(ir_3), .ir_4(ir_4),
        .funct(funct), .pc(pc), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Memory responder: acks after wait_n wait cycles, logs accesses, watches port stability
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (illegal === 1'b1) ill_cnt = ill_cnt + 1;
        if (auto_ack && mem_req === 1'b1) begin
            if (!busy) begin
                busy = 1'b1; s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata; s_pc = pc;
            end else begin
                stab_n = stab_n + 1;
                if (mem_addr !== s_addr || mem_we !== s_we || pc !== s_pc ||
                    (s_we && mem_wdata !== s_wdata)) stab_bad = stab_bad + 1;
            end
            if (wcnt >= wait_n) begin
                a_ack = 1'b1;
                a_rdata = mem[mem_addr];
                if (mem_we) mem[mem_addr] = mem_wdata;
                la.push_back(mem_addr);
                lc.push_back(cyc);
                wcnt = 0;
                busy = 1'b0;
            end else begin
                a_ack = 1'b0;
                wcnt = wcnt + 1;
            end
        end else begin
            a_ack = 1'b0;
            wcnt = 0;
            busy = 1'b0;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 16'hF000;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        @(posedge clk); #1 rst = 1'b0;
        while (halted !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL run_timeout halted=%b required=1", halted);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (pc !== 16'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0000", pc); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", mem_req); end
        checks++; if (halted !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL rst_flags halted=%b illegal=%b exp=0 0", halted, illegal); end
        checks++; if ({ir_1, ir_2, ir_3, ir_4, funct} !== 14'h0) begin failures++; $display("FAIL rst_ir got=%h exp=0", {ir_1, ir_2, ir_3, ir_4, funct}); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dut.rf[i] !== 16'h0) begin failures++; $display("FAIL rst_rf%0d got=%h exp=0000", i, dut.rf[i]); end
        end
        checks++; if (dut.z_q !== 1'b0 || dut.c_q !== 1'b0) begin failures++; $display("FAIL rst_zc got=%b%b exp=00", dut.z_q, dut.c_q); end
        clear_mem();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0 || mem_we !== 1'b0) begin failures++; $display("FAIL first_fetch req=%b addr=%h we=%b exp=1 0000 0", mem_req, mem_addr, mem_we); end
        run(50);
    endtask

    task automatic test_alu_basic();
        int b;
        do_reset();
        clear_mem();
        mem[0] = 16'h1405; mem[1] = 16'h1803; mem[2] = 16'h0601;
        b = la.size();
        run(200);
        checks++; if (dut.rf[1] !== 16'h0002) begin failures++; $display("FAIL alu_r1 got=%h exp=0002", dut.rf[1]); end
        checks++; if (dut.rf[2] !== 16'h0003) begin failures++; $display("FAIL alu_r2 got=%h exp=0003", dut.rf[2]); end
        checks++; if (dut.z_q !== 1'b0 || dut.c_q !== 1'b1) begin failures++; $display("FAIL alu_zc got=%b%b exp=01", dut.z_q, dut.c_q); end
        checks++; if (la[b] !== 16'd0 || la[b+1] !== 16'd1 || la[b+2] !== 16'd2 || la[b+3] !== 16'd3) begin failures++; $display("FAIL alu_fetch_addr got=%h %h %h %h exp=0 1 2 3", la[b], la[b+1], la[b+2], la[b+3]); end
        checks++; if (lc[b+1] - lc[b] !== 3) begin failures++; $display("FAIL ldi_latency got=%0d exp=3", lc[b+1] - lc[b]); end
        checks++; if (lc[b+3] - lc[b+2] !== 4) begin failures++; $display("FAIL alu_latency got=%0d exp=4", lc[b+3] - lc[b+2]); end
        checks++; if (pc !== 16'd4 || ir_1 !== 4'hF) begin failures++; $display("FAIL alu_halt_pc pc=%h ir_1=%h exp=0004 f", pc, ir_1); end
    endtask

    task automatic test_add_carry();
        do_reset();
        clear_mem();
        mem[0] = 16'h1CFF;
        run(100);
        checks++; if (dut.rf[3] !== 16'hFFFF) begin failures++; $display("FAIL ldi_sext got=%h exp=ffff", dut.rf[3]); end
        do_reset();
        clear_mem();
        mem[0] = 16'h1405; mem[1] = 16'h1803; mem[2] = 16'h0601; mem[3] = 16'h1CFF; mem[4] = 16'h0D00;
        run(200);
        checks++; if (dut.rf[3] !== 16'h0001) begin failures++; $display("FAIL add_r3 got=%h exp=0001", dut.rf[3]); end
        checks++; if (dut.z_q !== 1'b0 || dut.c_q !== 1'b1) begin failures++; $display("FAIL add_zc got=%b%b exp=01", dut.z_q, dut.c_q); end
    endtask

    task automatic test_mem_wait();
        int b, sb, sn;
        do_reset();
        clear_mem();
        mem[0] = 16'h1850; mem[1] = 16'h1477; mem[2] = 16'h3600; mem[3] = 16'h2E00;
        mem[16'h50] = 16'h0000;
        wait_n = 3;
        b = la.size(); sb = stab_bad; sn = stab_n;
        run(400);
        wait_n = 0;
        checks++; if (mem[16'h50] !== 16'h0077) begin failures++; $display("FAIL st_data got=%h exp=0077", mem[16'h50]); end
        checks++; if (dut.rf[3] !== 16'h0077) begin failures++; $display("FAIL ld_r3 got=%h exp=0077", dut.rf[3]); end
        checks++; if (la[b+3] !== 16'h0050 || la[b+5] !== 16'h0050) begin failures++; $display("FAIL mem_addr_log got=%h %h exp=0050 0050", la[b+3], la[b+5]); end
        checks++; if (stab_bad - sb !== 0) begin failures++; $display("FAIL port_stable got=%0d exp=0", stab_bad - sb); end
        checks++; if (stab_n - sn < 15) begin failures++; $display("FAIL wait_samples got=%0d exp>=15", stab_n - sn); end
        checks++; if (lc[b+1] - lc[b] !== 6) begin failures++; $display("FAIL ldi_wait_latency got=%0d exp=6", lc[b+1] - lc[b]); end
        checks++; if (lc[b+3] - lc[b+2] !== 5) begin failures++; $display("FAIL st_wait_latency got=%0d exp=5", lc[b+3] - lc[b+2]); end
        checks++; if (dut.z_q !== 1'b0 || dut.c_q !== 1'b0) begin failures++; $display("FAIL ldst_flags got=%b%b exp=00", dut.z_q, dut.c_q); end
    endtask

    task automatic test_branch();
        int b;
        logic [15:0] exp_a [7];
        exp_a = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd2, 16'd3, 16'd4};
        do_reset();
        clear_mem();
        mem[0] = 16'h1407; mem[1] = 16'h1807; mem[2] = 16'h0601; mem[3] = 16'h40FE;
        b = la.size();
        run(300);
        for (int i = 0; i < 7; i++) begin
            checks++; if (la[b+i] !== exp_a[i]) begin failures++; $display("FAIL bz_fetch%0d got=%h exp=%h", i, la[b+i], exp_a[i]); end
        end
        checks++; if (lc[b+4] - lc[b+3] !== 3) begin failures++; $display("FAIL bz_latency got=%0d exp=3", lc[b+4] - lc[b+3]); end
        checks++; if (dut.rf[1] !== 16'hFFF9 || dut.z_q !== 1'b0 || dut.c_q !== 1'b0) begin failures++; $display("FAIL bz_final r1=%h zc=%b%b exp=fff9 00", dut.rf[1], dut.z_q, dut.c_q); end
        checks++; if (pc !== 16'd5) begin failures++; $display("FAIL bz_pc got=%h exp=0005", pc); end
    endtask

    task automatic test_wrap();
        int b;
        do_reset();
        clear_mem();
        mem[0] = 16'h40FE; mem[1] = 16'h0000; mem[2] = 16'h40FD;
        b = la.size();
        run(200);
        checks++; if (la[b+3] !== 16'h0000 || la[b+4] !== 16'hFFFF) begin failures++; $display("FAIL wrap_fetch got=%h %h exp=0000 ffff", la[b+3], la[b+4]); end
        checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL wrap_pc got=%h exp=0000", pc); end
    endtask

    task automatic test_illegal_halt();
        int b, ib, reqs;
        do_reset();
        clear_mem();
        mem[0] = 16'h1405; mem[1] = 16'h5000; mem[2] = 16'hF000;
        b = la.size(); ib = ill_cnt;
        run(200);
        checks++; if (ill_cnt - ib !== 1) begin failures++; $display("FAIL illegal_pulse got=%0d exp=1", ill_cnt - ib); end
        checks++; if (lc[b+2] - lc[b+1] !== 2) begin failures++; $display("FAIL illegal_latency got=%0d exp=2", lc[b+2] - lc[b+1]); end
        checks++; if (dut.rf[1] !== 16'h0005 || dut.rf[0] !== 16'h0 || dut.rf[2] !== 16'h0) begin failures++; $display("FAIL illegal_regs r0=%h r1=%h r2=%h exp=0000 0005 0000", dut.rf[0], dut.rf[1], dut.rf[2]); end
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b0) reqs++;
        end
        checks++; if (reqs !== 0 || halted !== 1'b1) begin failures++; $display("FAIL halt_quiet reqs=%0d halted=%b exp=0 1", reqs, halted); end
        do_reset();
        @(negedge clk);
        checks++; if (pc !== 16'h0 || halted !== 1'b0) begin failures++; $display("FAIL halt_reset pc=%h halted=%b exp=0000 0", pc, halted); end
    endtask

    task automatic test_reset_abort();
        auto_ack = 1'b0;
        @(negedge clk);
        checks++; if (dut.rf[1] !== 16'h0) begin failures++; $display("FAIL abort_rf_reset got=%h exp=0000", dut.rf[1]); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0) begin failures++; $display("FAIL abort_pending req=%b addr=%h exp=1 0000", mem_req, mem_addr); end
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b1; man_ack = 1'b1; man_rdata = 16'h1405;
        @(negedge clk);
        checks++; if (pc !== 16'h0 || ir_1 !== 4'h0 || mem_req !== 1'b0) begin failures++; $display("FAIL rst_wins pc=%h ir_1=%h req=%b exp=0000 0 0", pc, ir_1, mem_req); end
        @(negedge clk);
        checks++; if (dut.rf[1] !== 16'h0 || halted !== 1'b0 || illegal !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL stale_ack r1=%h halted=%b illegal=%b we=%b exp=0000 0 0 0", dut.rf[1], halted, illegal, mem_we); end
        @(posedge clk); #1 rst = 1'b0; man_ack = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0 || pc !== 16'h0) begin failures++; $display("FAIL abort_refetch req=%b addr=%h pc=%h exp=1 0000 0000", mem_req, mem_addr, pc); end
        @(posedge clk); #1 auto_ack = 1'b1;
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_add_carry();
        test_mem_wait();
        test_branch();
        test_wrap();
        test_illegal_halt();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
